// File: rtl/seg_display_scanner.sv
// Multiplexes six 7-segment digit codes onto one shared active-low segment bus.
// Latency: outputs are a combinational decode of registered scan state (zero cycles vs state).
// Backpressure: none; the scan free-runs and inputs are sampled once per frame.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high reset; outputs are forced dark while it is high
//   seg_in     active-high segment codes, slot k at seg_in[7k+6:7k] (slot 0 = seconds units)
//   set_time   edit mode; enables blinking of the slot selected by sel_digit
//   sel_digit  slot under edit; values >= NUM_DIGITS blink nothing
//   dp_in      per-slot decimal point request, active-high (only with DISP_DP_EN)
//   an_n       anode enables, active-low, at most one low at a time
//   seg_n      segment drive, active-low
//   dp_n       decimal point drive, active-low
//
// Build option: define DISP_DP_EN to drive dp_n from dp_in; otherwise dp_n is tied high.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic                    set_time,
  input  logic [2:0]              sel_digit,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n
);

  // Counter widths, guarded so a degenerate parameter of 1 still yields a 1-bit counter.
  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_LIM = PRESC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]   FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0]      presc_q,     presc_d;
  logic [IDX_W-1:0]        idx_q,       idx_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    blink_ph_q,  blink_ph_d;
  logic [7*NUM_DIGITS-1:0] snap_q,      snap_d;

  logic presc_wrap;
  logic frame_end;
  logic frame_start;

  always_comb begin
    presc_wrap  = (presc_q == PRESC_MAX);
    frame_end   = presc_wrap && (idx_q == IDX_MAX);
    frame_start = (presc_q == '0) && (idx_q == '0);

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // Capture every digit at once at the top of the frame so a time update
    // landing mid-frame never shows half old, half new digits.
    snap_d = frame_start ? seg_in : snap_q;

    // Blink phase only runs in edit mode; leaving edit mode parks it at the
    // visible phase so re-entering always starts with the digit shown.
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!set_time) begin
      frame_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (frame_end) begin
      if (frame_cnt_q == FRM_MAX) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      snap_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      snap_q      <= snap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic [6:0] cur_code;
  logic       in_blank;
  logic       blink_dark;
  logic       slot_dark;

  always_comb begin
    // Mux the current slot's code out of the snapshot with a compare loop so
    // an idx value beyond NUM_DIGITS-1 can never select outside the vector.
    cur_code = 7'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (32'(idx_q) == k) begin
        cur_code = snap_q[7*k +: 7];
      end
    end

    // Leading blank cycles let the previous slot's segments discharge before
    // the next anode turns on (anti-ghosting).
    in_blank   = (presc_q < BLANK_LIM);
    // sel_digit >= NUM_DIGITS never matches because idx never gets there.
    blink_dark = blink_ph_q && (32'(sel_digit) == 32'(idx_q));
    slot_dark  = reset || in_blank || blink_dark;

    an_n  = slot_dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_n = slot_dark ? 7'h7F : ~cur_code;
  end

`ifdef DISP_DP_EN
  // Decimal points are read live rather than from the snapshot so a colon
  // can be flashed independently of the digit update rate.
  logic cur_dp;

  always_comb begin
    cur_dp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (32'(idx_q) == k) begin
        cur_dp = dp_in[k];
      end
    end
    dp_n = slot_dark ? 1'b1 : ~cur_dp;
  end
`else
  logic dp_in_unused;

  assign dp_in_unused = ^dp_in;
  assign dp_n         = 1'b1;
`endif

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with default parameters (frame = 24 cycles).
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [41:0] seg_in;
  logic        set_time;
  logic [2:0]  sel_digit;
  logic [5:0]  dp_in;
  logic [5:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  int vectors     = 0;
  int miscompares = 0;

  // Digit codes {hrT,hrU,minT,minU,secT,secU} = 7D,6D,66,5B,3F,06.
  localparam logic [41:0] BASE = {7'h7D, 7'h6D, 7'h66, 7'h5B, 7'h3F, 7'h06};

  logic [5:0] an_tab  [6];
  logic [6:0] segn_tab[6];

  always #5 clk = ~clk;

  seg_display_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .set_time  (set_time),
    .sel_digit (sel_digit),
    .dp_in     (dp_in),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [5:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e);
    vectors++;
    assert (an_n === an_e) else begin
      miscompares++;
      $error("FAIL %s c=%0d an_n got %b expected %b", tag, c, an_n, an_e);
    end
    vectors++;
    assert (seg_n === seg_e) else begin
      miscompares++;
      $error("FAIL %s c=%0d seg_n got %h expected %h", tag, c, seg_n, seg_e);
    end
    vectors++;
    assert (dp_n === dp_e) else begin
      miscompares++;
      $error("FAIL %s c=%0d dp_n got %b expected %b", tag, c, dp_n, dp_e);
    end
  endtask

  // mode 0: plain scan, slot 2 code changes at cycle 5 (anti-tear)
  // mode 1: blink on slot 2, set_time dropped at cycle 150 (frame 6, dark phase)
  // mode 2: sel_digit out of range, decimal points requested on slots 2 and 4
  task automatic run(input int mode, input int n);
    int         slot;
    int         p;
    int         f;
    logic       dark;
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    for (int c = 0; c < n; c++) begin
      if (mode == 0 && c == 5)   seg_in[20:14] = 7'h4F;
      if (mode == 1 && c == 150) set_time = 1'b0;
      #1;
      slot = (c / 4) % 6;
      p    = c % 4;
      f    = c / 24;
      dark = (p == 0);
      if (mode == 1 && slot == 2 && (f == 2 || f == 3)) dark = 1'b1;
      seg_e = segn_tab[slot];
      if (mode == 0 && slot == 2 && c >= 24) seg_e = 7'h30;
      dp_e = 1'b1;
`ifdef DISP_DP_EN
      if (mode == 2 && !dark && (slot == 2 || slot == 4)) dp_e = 1'b0;
`endif
      an_e = an_tab[slot];
      if (dark) begin
        an_e  = 6'h3F;
        seg_e = 7'h7F;
      end
      chk($sformatf("scan_m%0d", mode), c, an_e, seg_e, dp_e);
      step();
    end
  endtask

  initial begin
    an_tab   = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    segn_tab = '{7'h79, 7'h40, 7'h24, 7'h19, 7'h12, 7'h02};

    // Reset state and forced-dark outputs.
    reset     = 1'b1;
    seg_in    = BASE;
    set_time  = 1'b0;
    sel_digit = 3'd7;
    dp_in     = 6'b000000;
    step();
    step();
    chk("reset_hold", -1, 6'h3F, 7'h7F, 1'b1);

    // Two frames of plain scan with a mid-frame change to slot 2.
    reset = 1'b0;
    run(0, 48);

    // Reset mid-scan at idx=3, presc=2 (cycle 14), with a new slot 0 code.
    seg_in = BASE;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("pre_mid_reset", 14, 6'b110111, 7'h19, 1'b1);
    seg_in[6:0] = 7'h07;
    reset       = 1'b1;
    #1;
    chk("mid_reset_forced", 14, 6'h3F, 7'h7F, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk("mid_reset_c0", 0, 6'h3F, 7'h7F, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("mid_reset_slot0", i, 6'b111110, 7'h78, 1'b1);
    end

    // Blink on slot 2 from reset, then leave edit mode during a dark phase.
    seg_in    = BASE;
    set_time  = 1'b1;
    sel_digit = 3'd2;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    run(1, 192);

    // Out-of-range sel_digit blinks nothing; decimal points on slots 2 and 4.
    set_time  = 1'b1;
    sel_digit = 3'd6;
    dp_in     = 6'b010100;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    run(2, 96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
